// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared types for the LC-3b memory arbiter: word type, arbiter state and request record.
package lc3b_mem_arbiter_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } lc3b_arb_state;

    typedef struct packed {
        lc3b_word   addr;
        lc3b_word   wdata;
        logic [1:0] be;
        logic       read;
        logic       write;
    } lc3b_mem_req;

endpackage

// File: rtl/lc3b_mem_arbiter_sat_counter.sv
// Saturating up-counter: counts inc pulses and holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // Count register: clear on reset, step on inc unless already at full scale.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// Arbitrates the LC-3b IF and MEM word ports onto one downstream port with
// data priority, a bounded data streak to keep IF from starving, and
// saturating performance counters.
module lc3b_mem_arbiter
    import lc3b_mem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 if_memread,
    input  logic [15:0]          if_memaddr,
    input  logic [1:0]           if_mem_byte_enable,
    output logic                 if_mem_resp,
    output logic [15:0]          if_mem_rdata,

    input  logic                 mem_memread,
    input  logic                 mem_memwrite,
    input  logic [15:0]          mem_memaddr,
    input  logic [15:0]          mem_mem_wdata,
    input  logic [1:0]           mem_mem_byte_enable,
    output logic                 mem_mem_resp,
    output logic [15:0]          mem_mem_rdata,

    output logic                 dn_read,
    output logic                 dn_write,
    output logic [15:0]          dn_address,
    output logic [15:0]          dn_wdata,
    output logic [1:0]           dn_byte_enable,
    input  logic                 dn_resp,
    input  logic [15:0]          dn_rdata,

    output logic [CNT_WIDTH-1:0] if_grant_count,
    output logic [CNT_WIDTH-1:0] d_grant_count,
    output logic [CNT_WIDTH-1:0] wait_count
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    lc3b_arb_state state_q, state_d;
    lc3b_mem_req   req_q, req_d;
    logic [SW-1:0] d_streak_q, d_streak_d;

    logic d_req;
    logic if_done;
    logic d_done;
    logic wait_inc;

    assign d_req = mem_memread | mem_memwrite;

    // Next-state logic: IDLE takes the arbitration decision, GRANT_x waits for dn_resp.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        d_streak_d = d_streak_q;
        unique case (state_q)
            IDLE: begin
                if (d_req && !(if_memread && (d_streak_q == STREAK_MAX))) begin
                    state_d     = GRANT_D;
                    req_d.addr  = mem_memaddr;
                    req_d.wdata = mem_mem_wdata;
                    req_d.be    = mem_mem_byte_enable;
                    req_d.read  = mem_memread;
                    req_d.write = mem_memwrite;
                    if (!if_memread) begin
                        d_streak_d = '0;
                    end else if (d_streak_q != STREAK_MAX) begin
                        d_streak_d = d_streak_q + 1'b1;
                    end
                end else if (if_memread) begin
                    state_d     = GRANT_I;
                    req_d.addr  = if_memaddr;
                    req_d.wdata = '0;
                    req_d.be    = if_mem_byte_enable;
                    req_d.read  = 1'b1;
                    req_d.write = 1'b0;
                    d_streak_d  = '0;
                end
            end
            GRANT_I, GRANT_D: begin
                // Strobes drop at the edge after completion, forcing one IDLE cycle.
                if (dn_resp) begin
                    state_d     = IDLE;
                    req_d.read  = 1'b0;
                    req_d.write = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, request and streak registers; reset abandons any open transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= '0;
            d_streak_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            d_streak_q <= d_streak_d;
        end
    end

    assign dn_read        = req_q.read;
    assign dn_write       = req_q.write;
    assign dn_address     = req_q.addr;
    assign dn_wdata       = req_q.wdata;
    assign dn_byte_enable = req_q.be;

    // A response is forwarded only if its requester is still asking for it.
    assign if_done = !reset && (state_q == GRANT_I) && dn_resp && if_memread;
    assign d_done  = !reset && (state_q == GRANT_D) && dn_resp && d_req;

    assign if_mem_resp   = if_done;
    assign if_mem_rdata  = if_done ? dn_rdata : 16'h0000;
    assign mem_mem_resp  = d_done;
    assign mem_mem_rdata = d_done ? dn_rdata : 16'h0000;

    assign wait_inc = (if_memread && (state_q != GRANT_I)) ||
                      (d_req && (state_q != GRANT_D));

    sat_counter #(.WIDTH(CNT_WIDTH)) u_if_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (if_done),
        .count (if_grant_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_d_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (d_done),
        .count (d_grant_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wait_inc),
        .count (wait_count)
    );

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Directed bench for lc3b_mem_arbiter: inputs change on the falling edge,
// outputs are checked 1 time unit later.
module tb_lc3b_mem_arbiter;
    import lc3b_mem_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    logic        if_memread;
    logic [15:0] if_memaddr;
    logic [1:0]  if_mem_byte_enable;
    logic        if_mem_resp;
    logic [15:0] if_mem_rdata;
    logic        mem_memread;
    logic        mem_memwrite;
    logic [15:0] mem_memaddr;
    logic [15:0] mem_mem_wdata;
    logic [1:0]  mem_mem_byte_enable;
    logic        mem_mem_resp;
    logic [15:0] mem_mem_rdata;
    logic        dn_read;
    logic        dn_write;
    logic [15:0] dn_address;
    logic [15:0] dn_wdata;
    logic [1:0]  dn_byte_enable;
    logic        dn_resp;
    logic [15:0] dn_rdata;
    logic [15:0] if_grant_count;
    logic [15:0] d_grant_count;
    logic [15:0] wait_count;

    int vectors = 0;
    int errors  = 0;

    lc3b_mem_arbiter #(.MAX_D_STREAK(4), .CNT_WIDTH(16)) dut (
        .clk                 (clk),
        .reset               (reset),
        .if_memread          (if_memread),
        .if_memaddr          (if_memaddr),
        .if_mem_byte_enable  (if_mem_byte_enable),
        .if_mem_resp         (if_mem_resp),
        .if_mem_rdata        (if_mem_rdata),
        .mem_memread         (mem_memread),
        .mem_memwrite        (mem_memwrite),
        .mem_memaddr         (mem_memaddr),
        .mem_mem_wdata       (mem_mem_wdata),
        .mem_mem_byte_enable (mem_mem_byte_enable),
        .mem_mem_resp        (mem_mem_resp),
        .mem_mem_rdata       (mem_mem_rdata),
        .dn_read             (dn_read),
        .dn_write            (dn_write),
        .dn_address          (dn_address),
        .dn_wdata            (dn_wdata),
        .dn_byte_enable      (dn_byte_enable),
        .dn_resp             (dn_resp),
        .dn_rdata            (dn_rdata),
        .if_grant_count      (if_grant_count),
        .d_grant_count       (d_grant_count),
        .wait_count          (wait_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] exp_d;
        logic [9:0] exp_i;

        reset = 1'b1;
        if_memread = 1'b0;  if_memaddr = '0;  if_mem_byte_enable = '0;
        mem_memread = 1'b0; mem_memwrite = 1'b0; mem_memaddr = '0;
        mem_mem_wdata = '0; mem_mem_byte_enable = '0;
        dn_resp = 1'b0;     dn_rdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_dn_read", 32'(dn_read), 32'd0);
        chk("rst_dn_addr", 32'(dn_address), 32'd0);
        chk("rst_streak", 32'(dut.d_streak_q), 32'd0);
        chk("rst_counts", {if_grant_count, d_grant_count | wait_count}, 32'd0);
        reset = 1'b0;

        // Test 1: IF read of 0x3000, dn_resp on the third strobe cycle
        if_memread = 1'b1; if_memaddr = 16'h3000; if_mem_byte_enable = 2'b11;
        @(negedge clk); #1;
        chk("t1_dn_read_c1", 32'(dn_read), 32'd1);
        chk("t1_dn_addr", 32'(dn_address), 32'h3000);
        chk("t1_resp_c1", 32'(if_mem_resp), 32'd0);
        @(negedge clk); #1;
        chk("t1_dn_read_c2", 32'(dn_read), 32'd1);
        @(negedge clk);
        dn_resp = 1'b1; dn_rdata = 16'h1234;
        #1;
        chk("t1_dn_read_c3", 32'(dn_read), 32'd1);
        chk("t1_if_resp", 32'(if_mem_resp), 32'd1);
        chk("t1_if_rdata", 32'(if_mem_rdata), 32'h1234);
        chk("t1_d_resp", 32'(mem_mem_resp), 32'd0);
        @(negedge clk);
        if_memread = 1'b0; dn_resp = 1'b0; dn_rdata = 16'h0000;
        #1;
        chk("t1_dn_read_end", 32'(dn_read), 32'd0);
        chk("t1_if_resp_end", 32'(if_mem_resp), 32'd0);
        chk("t1_if_count", 32'(if_grant_count), 32'd1);
        chk("t1_wait", 32'(wait_count), 32'd1);

        // Test 2: data write 0xBEEF to 0x4002, upper byte only
        mem_memwrite = 1'b1; mem_memaddr = 16'h4002;
        mem_mem_wdata = 16'hBEEF; mem_mem_byte_enable = 2'b10;
        @(negedge clk);
        dn_resp = 1'b1; dn_rdata = 16'h5555;
        #1;
        chk("t2_dn_write", 32'(dn_write), 32'd1);
        chk("t2_dn_read", 32'(dn_read), 32'd0);
        chk("t2_dn_addr", 32'(dn_address), 32'h4002);
        chk("t2_dn_wdata", 32'(dn_wdata), 32'hBEEF);
        chk("t2_dn_be", 32'(dn_byte_enable), 32'h2);
        chk("t2_d_resp", 32'(mem_mem_resp), 32'd1);
        chk("t2_d_rdata", 32'(mem_mem_rdata), 32'h5555);
        chk("t2_if_resp", 32'(if_mem_resp), 32'd0);
        @(negedge clk);
        mem_memwrite = 1'b0; dn_resp = 1'b0; dn_rdata = 16'h0000;
        #1;
        chk("t2_dn_write_end", 32'(dn_write), 32'd0);
        chk("t2_d_resp_end", 32'(mem_mem_resp), 32'd0);
        chk("t2_d_count", 32'(d_grant_count), 32'd1);
        chk("t2_if_count", 32'(if_grant_count), 32'd1);

        // Test 3: both ports requesting, downstream answers immediately: D,D,D,D,I
        exp_d = 10'b0010101010;
        exp_i = 10'b1000000000;
        if_memread = 1'b1; if_memaddr = 16'h3010;
        mem_memread = 1'b1; mem_memaddr = 16'h0100; mem_mem_byte_enable = 2'b11;
        dn_resp = 1'b1; dn_rdata = 16'hA5A5;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk($sformatf("t3_d_resp_c%0d", c), 32'(mem_mem_resp), 32'(exp_d[c]));
            chk($sformatf("t3_if_resp_c%0d", c), 32'(if_mem_resp), 32'(exp_i[c]));
            chk($sformatf("t3_d_rdata_c%0d", c), 32'(mem_mem_rdata),
                exp_d[c] ? 32'hA5A5 : 32'h0);
        end
        @(negedge clk);
        if_memread = 1'b0; mem_memread = 1'b0; dn_resp = 1'b0; dn_rdata = 16'h0000;
        #1;
        chk("t3_streak", 32'(dut.d_streak_q), 32'd0);
        chk("t3_if_count", 32'(if_grant_count), 32'd2);
        chk("t3_d_count", 32'(d_grant_count), 32'd5);

        // Test 4: IF request withdrawn mid-grant; response is discarded
        if_memread = 1'b1; if_memaddr = 16'h3100;
        @(negedge clk);
        if_memread = 1'b0;
        #1;
        chk("t4_dn_read", 32'(dn_read), 32'd1);
        @(negedge clk);
        dn_resp = 1'b1; dn_rdata = 16'h7777;
        #1;
        chk("t4_if_resp", 32'(if_mem_resp), 32'd0);
        chk("t4_if_rdata", 32'(if_mem_rdata), 32'd0);
        @(negedge clk);
        dn_resp = 1'b0;
        #1;
        chk("t4_dn_read_end", 32'(dn_read), 32'd0);
        chk("t4_if_count", 32'(if_grant_count), 32'd2);

        // Test 5: reset while dn_read is high; dn_resp during/after reset ignored
        if_memread = 1'b1; if_memaddr = 16'h3200;
        @(negedge clk);
        #1;
        chk("t5_dn_read_pre", 32'(dn_read), 32'd1);
        reset = 1'b1; dn_resp = 1'b1; dn_rdata = 16'h9999;
        #1;
        chk("t5_if_resp_in_rst", 32'(if_mem_resp), 32'd0);
        @(negedge clk);
        reset = 1'b0; if_memread = 1'b0;
        #1;
        chk("t5_dn_read", 32'(dn_read), 32'd0);
        chk("t5_state", 32'(dut.state_q), 32'(IDLE));
        chk("t5_if_resp", 32'(if_mem_resp), 32'd0);
        chk("t5_counts", {if_grant_count, d_grant_count | wait_count}, 32'd0);

        // Test 6: wait_count saturation with data stalled and IF pending
        dn_resp = 1'b0; dn_rdata = 16'h0000;
        if_memread = 1'b1; mem_memread = 1'b1; mem_memaddr = 16'h0200;
        repeat (65534) @(negedge clk);
        #1;
        chk("t6_wait_fffe", 32'(wait_count), 32'hFFFE);
        chk("t6_state", 32'(dut.state_q), 32'(GRANT_D));
        repeat (2) @(negedge clk);
        #1;
        chk("t6_wait_ffff", 32'(wait_count), 32'hFFFF);
        repeat (3) @(negedge clk);
        #1;
        chk("t6_wait_hold", 32'(wait_count), 32'hFFFF);
        chk("t6_grants", {if_grant_count, d_grant_count}, 32'd0);

        if_memread = 1'b0; mem_memread = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/lc3b_mem_arbiter.md
Name: lc3b_mem_arbiter

Overview:
- Memory-side responder for the pipelined LC-3b core's two word ports: instruction fetch (IF, read-only) and data (MEM, read/write).
- Serialises both onto one downstream word port (cache or physical memory) and returns a single-cycle response to whichever core port was served.
- Applies data-priority arbitration with a starvation bound for IF, and exposes saturating grant and wait counters for performance reporting.

Parameters:
MAX_D_STREAK, 4, consecutive data grants allowed while an IF request is pending; after that the next grant goes to IF
CNT_WIDTH, 16, width of the performance counters (matches lc3b_word)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
if_memread  in  1  IF read request, held until if_mem_resp
if_memaddr  in  16  IF word address
if_mem_byte_enable  in  2  IF byte enables (forwarded unchanged)
if_mem_resp  out  1  IF transaction complete; if_mem_rdata valid this cycle
if_mem_rdata  out  16  IF read data
mem_memread  in  1  data read request
mem_memwrite  in  1  data write request (never asserted together with mem_memread)
mem_memaddr  in  16  data address
mem_mem_wdata  in  16  data write data
mem_mem_byte_enable  in  2  data byte enables
mem_mem_resp  out  1  data transaction complete
mem_mem_rdata  out  16  data read data
dn_read  out  1  downstream read strobe
dn_write  out  1  downstream write strobe
dn_address  out  16  downstream address
dn_wdata  out  16  downstream write data
dn_byte_enable  out  2  downstream byte enables
dn_resp  in  1  downstream completion pulse
dn_rdata  in  16  downstream read data, valid with dn_resp
if_grant_count  out  CNT_WIDTH  completed IF transactions, saturating
d_grant_count  out  CNT_WIDTH  completed data transactions, saturating
wait_count  out  CNT_WIDTH  cycles with at least one unserved pending request, saturating

Behaviour:

Reset:
- state = IDLE.
- dn_read, dn_write, dn_address, dn_wdata, dn_byte_enable = 0.
- d_streak = 0.
- All three counters = 0.
- if_mem_resp and mem_mem_resp = 0.
- Reset asserted mid-transaction abandons it: dn strobes are low the cycle after reset is sampled, and any dn_resp arriving during or after reset is ignored.

FSM states: IDLE, GRANT_I, GRANT_D.
- d_req = mem_memread | mem_memwrite.
- Decision in IDLE:
  - If d_req and not (if_memread and d_streak == MAX_D_STREAK): go to GRANT_D. Latch mem_* address, wdata, byte enables and read/write into the request register.
  - Else if if_memread: go to GRANT_I. Latch if_* fields, set write = 0 and wdata = 0.
  - Else stay in IDLE.
- Downstream outputs are registered from the request register.
  - dn_read or dn_write is asserted from the cycle after the decision and held until dn_resp.
  - Later changes on upstream address/data are ignored.
- In GRANT_x with dn_resp = 1:
  - Assert the matching upstream resp combinationally in the same cycle.
  - Pass dn_rdata through to the matching upstream rdata (for a write, rdata = dn_rdata with no meaning).
  - Drop the dn strobes at the next edge and return to IDLE.
  - Minimum turnaround is one IDLE cycle between transactions.
- Upstream resp is gated by the requester still asserting its request. If the requester dropped its request mid-grant, the downstream transaction still completes and the response is discarded. It is not counted as a grant.
- Non-granted port resp is always 0. Upstream rdata outputs are 0 when their resp is 0.
- Latency: request seen in IDLE at cycle N gives dn strobe at N+1; resp at cycle N+1+k, where k ≥ 0 is the downstream wait.

d_streak:
- Incremented on a GRANT_D decision taken while if_memread = 1, saturating at MAX_D_STREAK.
- Cleared on any GRANT_I decision.
- Cleared on a GRANT_D decision taken with if_memread = 0.

Simultaneous requests:
- Data wins unless the streak limit is reached, in which case IF wins.

Counters:
- Grant counters increment on a forwarded resp.
- wait_count increments each cycle where (if_memread and not serving IF) or (d_req and not serving D).
- IDLE counts as not serving.
- All counters hold at 2^CNT_WIDTH − 1.

Decomposition:
- lc3b_types (shared package) gains:
  - enum lc3b_arb_state {IDLE, GRANT_I, GRANT_D};
  - struct lc3b_mem_req {lc3b_word addr; lc3b_word wdata; logic[1:0] be; logic read; logic write;}.
- One sub-module, sat_counter: parameterised width; inputs clk, reset, inc; output count saturating. Instantiated three times.

Test Plan:
1. IF only: addr 0x3000, dn_resp 2 cycles after dn_read with rdata 0x1234 → dn_address=0x3000, dn_read high cycles 1–3, if_mem_resp pulses once with rdata 0x1234; if_grant_count=1.
2. Data write: addr 0x4002, wdata 0xBEEF, be 2'b10 → dn_write=1, dn_wdata=0xBEEF, dn_byte_enable=2'b10; mem_mem_resp one cycle; d_grant_count=1; if_mem_resp stays 0.
3. Both requesting from cycle 0, dn_resp immediate: data served first. With data re-requesting continuously, grant order is D,D,D,D,I (MAX_D_STREAK=4); d_streak is 0 after the IF grant.
4. IF drops if_memread during GRANT_I → dn transaction completes, if_mem_resp stays 0, if_grant_count unchanged.
5. Reset asserted while dn_read=1 → next cycle dn_read=0, state IDLE, all counters 0; a dn_resp arriving in that cycle produces no upstream resp.
6. Preload wait_count to 0xFFFE (CNT_WIDTH=16) via a held pending request → after 2 more wait cycles the count reads 0xFFFF and stays there.
